// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run sequencer that launches and supervises the core.
package run_ctrl_pkg;

  localparam int CW_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    FIN    = 3'd4,
    FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: start/done handshake, core reset window, launch pulse,
// RUN-cycle counting with timeout, and freeze on completion or fault.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CW      = CW_DEFAULT,
  parameter int RST_CYC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] max_cycles,
  input  logic          core_done,
  output logic          core_rst,
  output logic          core_req,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] cycle_cnt
);

  localparam int            HW        = $clog2(RST_CYC) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);

  state_t        state_q, state_d;
  logic          start_q;
  logic          launch;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] cyc_inc;
  logic          core_rst_q, core_req_q, busy_q, done_q, err_q;

  assign launch  = (state_q == IDLE) && start && !start_q && !abort;
  assign cyc_inc = (cycle_cnt == '1) ? cycle_cnt : (cycle_cnt + CW'(1));

  sat_counter #(.W(HW)) u_hold_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (launch),
    .en    (state_q == HOLD),
    .cnt   (hold_cnt)
  );

  // The cycle counter still advances in the cycle an abort or core_done is seen.
  sat_counter #(.W(CW)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (launch),
    .en    (state_q == RUN),
    .cnt   (cycle_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = HOLD; else state_d = IDLE;
      HOLD:    if (abort) state_d = IDLE;
               else if (hold_cnt == HOLD_LAST) state_d = LAUNCH;
               else state_d = HOLD;
      LAUNCH:  if (abort) state_d = IDLE; else state_d = RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (core_done) state_d = FIN;
               else if ((max_cycles != '0) && (cyc_inc == max_cycles)) state_d = FAULT;
               else state_d = RUN;
      FIN,
      FAULT:   if (abort || !start) state_d = IDLE; else state_d = state_q;
      default: state_d = IDLE;
    endcase
  end

  // A start level already high at reset release is stale, so start_q resets high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b1;
      core_rst_q <= 1'b1;
      core_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      core_rst_q <= !((state_d == LAUNCH) || (state_d == RUN));
      core_req_q <= (state_d == LAUNCH);
      busy_q     <= (state_d == HOLD) || (state_d == LAUNCH) || (state_d == RUN);
      done_q     <= (state_d == FIN);
      err_q      <= (state_d == FAULT);
    end
  end

  assign core_rst = core_rst_q;
  assign core_req = core_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a cycle-level phase model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_run_ctrl;

  localparam int CW = 16;
  localparam int RST_CYC = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam int P_IDLE = 0, P_HOLD = 1, P_LAUNCH = 2, P_RUN = 3, P_FIN = 4, P_FAULT = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_reset = 1'b0;
  logic start = 1'b0, abort = 1'b0, core_done = 1'b0;
  logic [CW-1:0] max_cycles = '0;
  logic [3:0] max4 = 4'd0;
  logic core_rst, core_req, busy, done, err;
  logic [CW-1:0] cycle_cnt;
  logic s_core_rst, s_core_req, s_busy, s_done, s_err;
  logic [3:0] s_cycle_cnt;

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  int m_phase = P_IDLE, m_hold_left = 0, m_cnt = 0;
  bit m_prev = 1'b1;

  always #5 clk = ~clk;

  run_ctrl #(.CW(CW), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .max_cycles(max_cycles),
    .core_done(core_done), .core_rst(core_rst), .core_req(core_req), .busy(busy),
    .done(done), .err(err), .cycle_cnt(cycle_cnt)
  );

  run_ctrl #(.CW(4), .RST_CYC(RST_CYC)) dut_s (
    .clk(clk), .reset(s_reset), .start(start), .abort(abort), .max_cycles(max4),
    .core_done(core_done), .core_rst(s_core_rst), .core_req(s_core_req), .busy(s_busy),
    .done(s_done), .err(s_err), .cycle_cnt(s_cycle_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Phase model: phase, remaining HOLD cycles, and RUN-cycle count.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= P_IDLE; m_cnt <= 0; m_hold_left <= 0; m_prev <= 1'b1;
    end else begin
      int ph, hl, cn;
      ph = m_phase; hl = m_hold_left; cn = m_cnt;
      case (m_phase)
        P_IDLE:   if (!abort && start && !m_prev) begin ph = P_HOLD; hl = RST_CYC; cn = 0; end
        P_HOLD:   if (abort) ph = P_IDLE;
                  else begin hl = hl - 1; if (hl == 0) ph = P_LAUNCH; end
        P_LAUNCH: ph = abort ? P_IDLE : P_RUN;
        P_RUN: begin
          cn = (cn < SAT) ? cn + 1 : SAT;
          if (abort) ph = P_IDLE;
          else if (core_done) ph = P_FIN;
          else if (max_cycles != 0 && cn == int'(max_cycles)) ph = P_FAULT;
        end
        default:  if (abort || !start) ph = P_IDLE;
      endcase
      m_phase <= ph; m_hold_left <= hl; m_cnt <= cn; m_prev <= start;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_core_rst", core_rst, !(m_phase == P_LAUNCH || m_phase == P_RUN));
      chk("m_core_req", core_req, m_phase == P_LAUNCH);
      chk("m_busy", busy, m_phase == P_HOLD || m_phase == P_LAUNCH || m_phase == P_RUN);
      chk("m_done", done, m_phase == P_FIN);
      chk("m_err", err, m_phase == P_FAULT);
      chk("m_cycle_cnt", cycle_cnt, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // From IDLE with start low: raise start and stop inside RUN cycle 1.
  task automatic launch_run();
    start = 1'b1;
    repeat (RST_CYC + 2) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) cyc();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cycle_cnt, 0);
    reset = 1'b1;
    cyc();
    chk_en = 1'b1;

    // 1: basic run, done on RUN cycle 130
    start = 1'b1;
    for (int i = 0; i < RST_CYC; i++) begin
      cyc();
      chk("t1_hold_rst", core_rst, 1);
      chk("t1_hold_req", core_req, 0);
      chk("t1_hold_busy", busy, 1);
    end
    cyc();
    chk("t1_req_6th", core_req, 1);
    chk("t1_launch_rst", core_rst, 0);
    cyc();
    chk("t1_req_once", core_req, 0);
    repeat (129) cyc();
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_cnt", cycle_cnt, 130);
    chk("t1_fin_rst", core_rst, 1);
    cyc();
    chk("t1_hold_fin", done, 1);
    start = 1'b0;
    cyc();
    chk("t1_idle_done", done, 0);
    chk("t1_idle_cnt", cycle_cnt, 130);

    // 2: timeout at 50
    max_cycles = 16'd50;
    launch_run();
    repeat (49) cyc();
    chk("t2_pre_err", err, 0);
    cyc();
    chk("t2_err", err, 1);
    chk("t2_done", done, 0);
    chk("t2_cnt", cycle_cnt, 50);
    start = 1'b0;
    cyc();
    chk("t2_idle_err", err, 0);

    // 3: done and timeout together
    max_cycles = 16'd20;
    launch_run();
    repeat (19) cyc();
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_err", err, 0);
    chk("t3_cnt", cycle_cnt, 20);
    start = 1'b0;
    cyc();

    // 4: abort on RUN cycle 10, no relaunch while start stays high
    max_cycles = 16'd0;
    launch_run();
    repeat (9) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_rst", core_rst, 1);
    chk("t4_cnt", cycle_cnt, 10);
    repeat (3) cyc();
    chk("t4_no_relaunch", busy, 0);
    start = 1'b0;
    cyc();
    start = 1'b1;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t4_abort_blocks", busy, 0);
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    chk("t4_relaunch", busy, 1);
    chk("t4_relaunch_cnt", cycle_cnt, 0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    cyc();

    // 5: async reset at RUN cycle 7
    launch_run();
    repeat (6) cyc();
    #1;
    reset = 1'b0;
    #1;
    chk("t5_async_rst", core_rst, 1);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_cnt", cycle_cnt, 0);
    repeat (2) cyc();
    reset = 1'b1;
    repeat (4) cyc();
    chk("t5_no_launch", busy, 0);
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    chk("t5_relaunch", busy, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    cyc();

    // 6: 4-bit counter saturates and stays in RUN
    s_reset = 1'b1;
    cyc();
    launch_run();
    repeat (14) cyc();
    chk("t6_cnt14", s_cycle_cnt, 14);
    cyc();
    chk("t6_cnt15", s_cycle_cnt, 15);
    repeat (10) cyc();
    chk("t6_sat", s_cycle_cnt, 15);
    chk("t6_busy", s_busy, 1);
    chk("t6_rst", s_core_rst, 0);
    chk("t6_req", s_core_req, 0);
    chk("t6_done", s_done, 0);
    chk("t6_err", s_err, 0);
    chk("t6_main_cnt", cycle_cnt, 25);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    cyc();
    chk("t6_abort", s_busy, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
